// File: rtl/serial_nibble_pkg.sv
// serial_nibble_pkg: shared state type, framing constants and sizing helper for the nibble serial receiver.
package serial_nibble_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction
endpackage

// File: rtl/nibble_capture_shift.sv
// nibble_capture_shift: bidirectional capture shift register; Dir=1 shifts left inserting at [0], Dir=0 shifts right inserting at [WIDTH-1].
module nibble_capture_shift
   import serial_nibble_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Shift,
   input  logic             Dir,
   input  logic             Din,
   output logic [WIDTH-1:0] Q
);
   always_ff @(posedge Clock) begin
      if (!Resetn) Q <= '0;
      else if (Shift) Q <= Dir ? {Q[WIDTH-2:0], Din} : {Din, Q[WIDTH-1:1]};
   end
endmodule

// File: rtl/serial_nibble_receiver.sv
// serial_nibble_receiver: framed serial-to-parallel receiver with a one-entry valid/ready output buffer.
// Define SERIAL_NIBBLE_PARITY_EN to take an even-parity bit between the data bits and the stop bit.
module serial_nibble_receiver
   import serial_nibble_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             SerIn,
   input  logic             SerValid,
   input  logic             MsbFirst,
   output logic [WIDTH-1:0] Q,
   output logic             QValid,
   input  logic             QReady,
   output logic             FrameErr,
   output logic             Overrun,
   output logic             Busy
);
   localparam int CW = cnt_width(WIDTH);
   state_t state, next;
   logic [CW-1:0] cnt;
   logic dir;
   logic [WIDTH-1:0] word;
   logic start_seen, data_strobe, last_bit, stop_seen, good, par_ok;
   assign start_seen  = SerValid && state == IDLE && SerIn == START_BIT;
   assign data_strobe = SerValid && state == DATA;
   assign last_bit    = cnt == CW'(WIDTH - 1);
   assign stop_seen   = SerValid && state == STOP;
   assign good        = stop_seen && SerIn == STOP_BIT && par_ok;
   assign Busy        = state != IDLE;
`ifdef SERIAL_NIBBLE_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
   // Verdict is held until the stop bit so a bad parity still consumes the whole frame.
   always_ff @(posedge Clock) begin
      if (!Resetn) par_ok <= 1'b1;
      else if (SerValid && state == PARITY) par_ok <= SerIn == ^word;
   end
`else
   localparam state_t AFTER_DATA = STOP;
   assign par_ok = 1'b1;
`endif
   nibble_capture_shift #(.WIDTH(WIDTH)) u_shift (
      .Clock (Clock),
      .Resetn(Resetn),
      .Shift (data_strobe),
      .Dir   (dir),
      .Din   (SerIn),
      .Q     (word)
   );
   always_ff @(posedge Clock) begin
      if (!Resetn) state <= IDLE;
      else state <= next;
   end
   always_comb begin
      next = state;
      if (SerValid)
         case (state)
            IDLE:    next = SerIn == START_BIT ? DATA : IDLE;
            DATA:    next = last_bit ? AFTER_DATA : DATA;
            PARITY:  next = STOP;
            default: next = IDLE;
         endcase
   end
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         cnt <= '0;
         dir <= 1'b0;
      end else if (start_seen) begin
         cnt <= '0;
         dir <= MsbFirst;
      end else if (data_strobe) cnt <= cnt + CW'(1);
   end
   // A consume on the stop-bit edge frees the buffer for the new word in the same cycle.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         Q        <= '0;
         QValid   <= 1'b0;
         FrameErr <= 1'b0;
         Overrun  <= 1'b0;
      end else begin
         FrameErr <= stop_seen && !good;
         Overrun  <= good && QValid && !QReady;
         if (good && (!QValid || QReady)) begin
            Q      <= word;
            QValid <= 1'b1;
         end else if (QReady) QValid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_serial_nibble_receiver.sv
// tb_serial_nibble_receiver: scoreboard bench; words expected to be delivered are queued when sent and checked on each consume.
module tb_serial_nibble_receiver;
   logic clk = 1'b0;
   logic Resetn, SerIn, SerValid, MsbFirst, QReady;
   logic [3:0] Q;
   logic QValid, FrameErr, Overrun, Busy;
   int compared = 0, mismatched = 0, fe_cnt = 0, ov_cnt = 0;
   logic [3:0] sb[$];
`ifdef SERIAL_NIBBLE_PARITY_EN
   logic par_flip = 1'b0;
`endif
   always #5 clk = ~clk;

   serial_nibble_receiver #(.WIDTH(4)) dut (
      .Clock   (clk),
      .Resetn  (Resetn),
      .SerIn   (SerIn),
      .SerValid(SerValid),
      .MsbFirst(MsbFirst),
      .Q       (Q),
      .QValid  (QValid),
      .QReady  (QReady),
      .FrameErr(FrameErr),
      .Overrun (Overrun),
      .Busy    (Busy)
   );

   always @(negedge clk) begin
      if (Resetn === 1'b1) begin
         if (FrameErr === 1'b1) fe_cnt++;
         if (Overrun === 1'b1) ov_cnt++;
         compared++;
         if (FrameErr === 1'b1 && Overrun === 1'b1) begin
            mismatched++;
            $display("FAIL err_excl: FrameErr=%b Overrun=%b, required not both high", FrameErr, Overrun);
         end
         if (QValid === 1'b1 && QReady === 1'b1) begin
            compared++;
            if (sb.size() == 0) begin
               mismatched++;
               $display("FAIL sb_unexpected: got word %h, required no delivery", Q);
            end else begin
               logic [3:0] exp_w;
               exp_w = sb.pop_front();
               if (Q !== exp_w) begin
                  mismatched++;
                  $display("FAIL sb_word: got %h, required %h", Q, exp_w);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b, input int gap);
      SerValid = 1'b1;
      SerIn = b;
      tick();
      SerValid = 1'b0;
      SerIn = 1'b1;
      repeat (gap) tick();
   endtask

   task automatic send_frame(input logic [3:0] w, input logic msb, input logic stop_b, input int gap, input logic push, input logic rdy_at_stop);
      if (push) sb.push_back(w);
      MsbFirst = msb;
      drive_bit(1'b0, gap);
      for (int i = 0; i < 4; i++) drive_bit(msb ? w[3-i] : w[i], gap);
`ifdef SERIAL_NIBBLE_PARITY_EN
      drive_bit(^w ^ par_flip, gap);
`endif
      if (rdy_at_stop) QReady = 1'b1;
      drive_bit(stop_b, 0);
   endtask

   task automatic test_reset();
      Resetn = 1'b0; SerValid = 1'b0; SerIn = 1'b1; MsbFirst = 1'b0; QReady = 1'b1;
      repeat (2) tick();
      compared += 5;
      if (Q !== 4'h0) begin mismatched++; $display("FAIL rst_q: got %h, required 0", Q); end
      if (QValid !== 1'b0) begin mismatched++; $display("FAIL rst_qvalid: got %b, required 0", QValid); end
      if (FrameErr !== 1'b0) begin mismatched++; $display("FAIL rst_frameerr: got %b, required 0", FrameErr); end
      if (Overrun !== 1'b0) begin mismatched++; $display("FAIL rst_overrun: got %b, required 0", Overrun); end
      if (Busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b, required 0", Busy); end
      Resetn = 1'b1;
      tick();
   endtask

   task automatic test_lsb_first();
      QReady = 1'b1;
      send_frame(4'hD, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      compared += 4;
      if (QValid !== 1'b1) begin mismatched++; $display("FAIL lsb_qvalid: got %b, required 1", QValid); end
      if (Q !== 4'hD) begin mismatched++; $display("FAIL lsb_q: got %h, required d", Q); end
      if (FrameErr !== 1'b0) begin mismatched++; $display("FAIL lsb_frameerr: got %b, required 0", FrameErr); end
      if (Overrun !== 1'b0) begin mismatched++; $display("FAIL lsb_overrun: got %b, required 0", Overrun); end
      tick();
      compared++;
      if (QValid !== 1'b0) begin mismatched++; $display("FAIL lsb_qvalid_clear: got %b, required 0", QValid); end
   endtask

   task automatic test_msb_first();
      send_frame(4'hB, 1'b1, 1'b1, 0, 1'b1, 1'b0);
      compared += 2;
      if (QValid !== 1'b1) begin mismatched++; $display("FAIL msb_qvalid: got %b, required 1", QValid); end
      if (Q !== 4'hB) begin mismatched++; $display("FAIL msb_q: got %h, required b", Q); end
      tick();
      send_frame(4'hB, 1'b1, 1'b1, 3, 1'b1, 1'b0);
      compared += 2;
      if (QValid !== 1'b1) begin mismatched++; $display("FAIL msb_gap_qvalid: got %b, required 1", QValid); end
      if (Q !== 4'hB) begin mismatched++; $display("FAIL msb_gap_q: got %h, required b", Q); end
      tick();
   endtask

   task automatic test_stop_error();
      int fe0;
      fe0 = fe_cnt;
      send_frame(4'hF, 1'b0, 1'b0, 0, 1'b0, 1'b0);
      compared += 2;
      if (FrameErr !== 1'b1) begin mismatched++; $display("FAIL stop_frameerr: got %b, required 1", FrameErr); end
      if (QValid !== 1'b0) begin mismatched++; $display("FAIL stop_qvalid: got %b, required 0", QValid); end
      send_frame(4'hA, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      compared += 3;
      if (Q !== 4'hA || QValid !== 1'b1) begin mismatched++; $display("FAIL stop_next_frame: got q=%h v=%b, required q=a v=1", Q, QValid); end
      if (FrameErr !== 1'b0) begin mismatched++; $display("FAIL stop_next_frameerr: got %b, required 0", FrameErr); end
      if (fe_cnt - fe0 != 1) begin mismatched++; $display("FAIL stop_pulse_count: got %0d, required 1", fe_cnt - fe0); end
      tick();
   endtask

   task automatic test_overrun();
      int ov0;
      ov0 = ov_cnt;
      QReady = 1'b0;
      send_frame(4'h3, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      send_frame(4'h5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      compared += 3;
      if (Overrun !== 1'b1) begin mismatched++; $display("FAIL ovr_pulse: got %b, required 1", Overrun); end
      if (Q !== 4'h3 || QValid !== 1'b1) begin mismatched++; $display("FAIL ovr_hold: got q=%h v=%b, required q=3 v=1", Q, QValid); end
      if (FrameErr !== 1'b0) begin mismatched++; $display("FAIL ovr_frameerr: got %b, required 0", FrameErr); end
      send_frame(4'h9, 1'b0, 1'b1, 0, 1'b1, 1'b1);
      compared += 3;
      if (Overrun !== 1'b0) begin mismatched++; $display("FAIL ovr_consume_pulse: got %b, required 0", Overrun); end
      if (Q !== 4'h9 || QValid !== 1'b1) begin mismatched++; $display("FAIL ovr_consume_load: got q=%h v=%b, required q=9 v=1", Q, QValid); end
      if (ov_cnt - ov0 != 1) begin mismatched++; $display("FAIL ovr_pulse_count: got %0d, required 1", ov_cnt - ov0); end
      tick();
   endtask

   task automatic test_reset_mid_frame();
      QReady = 1'b0;
      send_frame(4'hC, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      MsbFirst = 1'b0;
      drive_bit(1'b0, 0);
      drive_bit(1'b1, 0);
      drive_bit(1'b0, 0);
      compared++;
      if (Busy !== 1'b1) begin mismatched++; $display("FAIL mid_busy_before: got %b, required 1", Busy); end
      Resetn = 1'b0;
      tick();
      Resetn = 1'b1;
      sb.delete();
      compared += 3;
      if (Busy !== 1'b0) begin mismatched++; $display("FAIL mid_busy: got %b, required 0", Busy); end
      if (QValid !== 1'b0) begin mismatched++; $display("FAIL mid_qvalid: got %b, required 0", QValid); end
      if (Q !== 4'h0) begin mismatched++; $display("FAIL mid_q: got %h, required 0", Q); end
      QReady = 1'b1;
      send_frame(4'h6, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      compared++;
      if (Q !== 4'h6 || QValid !== 1'b1) begin mismatched++; $display("FAIL mid_next_frame: got q=%h v=%b, required q=6 v=1", Q, QValid); end
      tick();
   endtask

`ifdef SERIAL_NIBBLE_PARITY_EN
   task automatic test_parity();
      QReady = 1'b1;
      par_flip = 1'b0;
      send_frame(4'h7, 1'b0, 1'b1, 0, 1'b1, 1'b0);
      compared++;
      if (Q !== 4'h7 || QValid !== 1'b1 || FrameErr !== 1'b0) begin mismatched++; $display("FAIL par_good: got q=%h v=%b fe=%b, required q=7 v=1 fe=0", Q, QValid, FrameErr); end
      tick();
      par_flip = 1'b1;
      send_frame(4'h7, 1'b0, 1'b1, 0, 1'b0, 1'b0);
      par_flip = 1'b0;
      compared++;
      if (FrameErr !== 1'b1 || QValid !== 1'b0) begin mismatched++; $display("FAIL par_bad: got fe=%b v=%b, required fe=1 v=0", FrameErr, QValid); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_lsb_first();
      test_msb_first();
      test_stop_error();
      test_overrun();
      test_reset_mid_frame();
`ifdef SERIAL_NIBBLE_PARITY_EN
      test_parity();
`endif
      repeat (3) tick();
      compared++;
      if (sb.size() != 0) begin mismatched++; $display("FAIL sb_drain: got %0d words pending, required 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
